pipelined_adder_nbits: RTL and testbench



---
 rtl/pipelined_adder_nbits.sv | 118 +++++++++++
 tb/tb_pipelined_adder_nbits.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_nbits.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES registered carry segments with valid/ready flow control.
// Define PIPE_ADDER_SUB_EN to add the sub port (a + ~b + 1 when sub = 1).
module pipelined_adder_nbits #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int SEG = WIDTH / STAGES;

    // Handshake: a side transfers on a cycle where its valid and ready are both 1.
    // The whole pipe shifts whenever the output slot is empty or being taken.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | c_in;
`else
    assign b_eff = b;
    assign c_eff = c_in;
`endif

    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
        logic [SEG-1:0] s;
        logic           c;
        s = '0;
        c = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SEG;
        localparam int REM = WIDTH - LO - SEG;

        logic                  valid_q;
        logic                  carry_q;
        logic [LO+SEG-1:0]     sum_q;

        logic                  valid_d;
        logic                  cin_d;
        logic [WIDTH-LO-1:0]   op_a;
        logic [WIDTH-LO-1:0]   op_b;
        logic [LO+SEG-1:0]     sum_d;
        logic [SEG:0]          seg_r;

        assign seg_r = seg_add(op_a[SEG-1:0], op_b[SEG-1:0], cin_d);

        if (k == 0) begin : g_src
            assign valid_d = in_valid;
            assign cin_d   = c_eff;
            assign op_a    = a;
            assign op_b    = b_eff;
            assign sum_d   = seg_r[SEG-1:0];
        end else begin : g_src
            assign valid_d = g_stage[k-1].valid_q;
            assign cin_d   = g_stage[k-1].carry_q;
            assign op_a    = g_stage[k-1].g_ops.a_q;
            assign op_b    = g_stage[k-1].g_ops.b_q;
            assign sum_d   = {seg_r[SEG-1:0], g_stage[k-1].sum_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= seg_r[SEG];
                sum_q   <= sum_d;
            end
        end

        // Only the operand bits still waiting for a later segment travel on.
        if (REM > 0) begin : g_ops
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= op_a[WIDTH-LO-1:SEG];
                    b_q <= op_b[WIDTH-LO-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign out_sum   = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].sum_q};

endmodule

// File: tb/tb_pipelined_adder_nbits.sv
// Directed and random bench for pipelined_adder_nbits; checks results, order, latency, stalls and reset flush.
module tb_pipelined_adder_nbits;
    parameter int STAGES = 4;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;

    always #5 clk = ~clk;

    pipelined_adder_nbits #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef PIPE_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum)
    );

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];
    int             cyc;
    int             errors;
    int             checks;
    int             n_in;
    int             n_out;
    bit             chk_lat;
    bit             ovr;
    logic [WIDTH:0] ovr_val;

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
        logic [WIDTH:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        return r;
    endfunction

    task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s, input logic v);
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = s;
        in_valid = v;
    endtask

    // One clock: scoreboard both handshakes at the negedge, then step past the rising edge.
    task automatic cycle();
        int lat;
        @(negedge clk);
        if (out_ready) check("in_ready_open", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", (WIDTH+1)'(out_valid), '0);
            end else begin
                lat = cyc - acc_q.pop_front();
                check("sum", out_sum, exp_q.pop_front());
                if (chk_lat) check("latency", (WIDTH+1)'(lat), (WIDTH+1)'(STAGES - 1));
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ovr ? ovr_val : model(a, b, c_in, sub));
            acc_q.push_back(cyc + 1);
            n_in++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send1(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s, input logic [WIDTH:0] want);
        drive(x, y, ci, s, 1'b1);
        ovr     = 1'b1;
        ovr_val = want;
        cycle();
        ovr     = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < STAGES + 20 && exp_q.size() > 0; i++) cycle();
        check("drain_empty", (WIDTH+1)'(exp_q.size()), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int i0;
        errors = 0; checks = 0; cyc = 0; n_in = 0; n_out = 0;
        chk_lat = 1'b0; ovr = 1'b0; ovr_val = '0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", (WIDTH+1)'(out_valid), '0);
        check("rst_out_sum", out_sum, '0);
        check("rst_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry across every segment, with exact latency
        chk_lat = 1'b1;
        n0 = n_out;
        send1(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
        drain();
        send1(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF);
        drain();
        send1(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000);
        drain();
        check("carry_count", (WIDTH+1)'(n_out - n0), (WIDTH+1)'(3));

`ifdef PIPE_ADDER_SUB_EN
        n0 = n_out;
        send1(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002);
        send1(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
        send1(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002);
        send1(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE);
        send1(16'h1234, 16'h0F0F, 1'b1, 1'b0, 17'h02144);
        drain();
        check("sub_count", (WIDTH+1)'(n_out - n0), (WIDTH+1)'(5));
`endif

        // Streaming: back-to-back random operands, fixed latency implies consecutive outputs
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            cycle();
        end
        drain();
        check("stream_count", (WIDTH+1)'(n_out - n0), (WIDTH+1)'(8));
        chk_lat = 1'b0;

        // Backpressure: fill, then hold out_ready low for 3 cycles
        n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            cycle();
        end
        out_ready = 1'b0;
        drive(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
            check("stall_in_ready", (WIDTH+1)'(in_ready), '0);
            check("stall_hold", out_sum, exp_q[0]);
            @(posedge clk);
            cyc++;
            #1;
        end
        drain();
        check("stall_count", (WIDTH+1)'(n_out - n0), (WIDTH+1)'(4));

        // Random valid/ready over 1000 accepted operations
        n0 = n_out;
        i0 = n_in;
        for (int c = 0; c < 8000 && (n_in - i0) < 1000; c++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                  1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();
        check("rand_accepted", (WIDTH+1)'(n_in - i0), (WIDTH+1)'(1000));
        check("rand_delivered", (WIDTH+1)'(n_out - n0), (WIDTH+1)'(1000));

        // Reset mid-stream with results in flight
        for (int i = 0; i < 4; i++) begin
            drive(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", (WIDTH+1)'(out_valid), '0);
        check("midrst_out_sum", out_sum, '0);
        check("midrst_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        out_ready = 1'b1;
        check("post_rst_valid", (WIDTH+1)'(out_valid), '0);
        n0 = n_out;
        for (int i = 0; i < STAGES + 6; i++) cycle();
        check("post_rst_no_stale", (WIDTH+1)'(n_out - n0), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
